// File: rtl/rs_alu_station_pkg.sv
// rs_pkg: shared constants, station entry record and tag helpers for the ALU reservation station
// Ports: none (package). Tags 0..ROB_N-1 name ROB entries; TAG_INVALID means the value is already known.
package rs_pkg;
    localparam int RS_N   = 4;
    localparam int ROB_N  = 8;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int IDX_W  = $clog2(RS_N);
    localparam int ROB_W  = $clog2(ROB_N);

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_INVALID = TAG_W'(8);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        tag_t              dst_tag;
        logic              a_rdy;
        tag_t              a_tag;
        logic [DATA_W-1:0] a_val;
        logic              b_rdy;
        tag_t              b_tag;
        logic [DATA_W-1:0] b_val;
    } rs_entry;

    function automatic logic tag_real(input tag_t t);
        return t < TAG_W'(ROB_N);
    endfunction

    function automatic logic [ROB_W-1:0] tag_idx(input tag_t t);
        return t[ROB_W-1:0];
    endfunction
endpackage

// File: rtl/rs_alu_station_if.sv
// rs_alu_station_if: dispatch and issue handshake bundle of the ALU reservation station
// Signals: disp_valid/op/tag/a_tag/b_tag/a_val/b_val and full (dispatch side),
//          iss_valid/ready/op/a/b/tag (issue side). slave = station, master = ID + ALU.
interface rs_alu_station_if;
    import rs_pkg::*;

    logic              disp_valid;
    logic [OP_W-1:0]   disp_op;
    tag_t              disp_tag;
    tag_t              disp_a_tag;
    tag_t              disp_b_tag;
    logic [DATA_W-1:0] disp_a_val;
    logic [DATA_W-1:0] disp_b_val;
    logic              full;
    logic              iss_valid;
    logic              iss_ready;
    logic [OP_W-1:0]   iss_op;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    tag_t              iss_tag;

    modport master (
        output disp_valid, disp_op, disp_tag, disp_a_tag, disp_b_tag, disp_a_val, disp_b_val, iss_ready,
        input  full, iss_valid, iss_op, iss_a, iss_b, iss_tag
    );

    modport slave (
        input  disp_valid, disp_op, disp_tag, disp_a_tag, disp_b_tag, disp_a_val, disp_b_val, iss_ready,
        output full, iss_valid, iss_op, iss_a, iss_b, iss_tag
    );
endinterface

// File: rtl/rs_alu_station_age_select.sv
// rs_age_select: age matrix of the station entries plus oldest-ready one-hot picker
// Ports: clk, rst (async, active-high), flush (clears all ages), alloc (one-hot newly
//        written entry, becomes youngest), free (one-hot departing entry), req (ready
//        entries), grant (one-hot oldest requesting entry, combinational).
module rs_age_select
    import rs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [RS_N-1:0] alloc,
    input  logic [RS_N-1:0] free,
    input  logic [RS_N-1:0] req,
    output logic [RS_N-1:0] grant
);
    // age[i][j] = 1: entry i was dispatched before entry j
    logic [RS_N-1:0] age [RS_N];
    logic            blocked;

    // A new entry is older than nobody (row cleared) and younger than everyone (column set).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_N; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < RS_N; i++)
                for (int j = 0; j < RS_N; j++)
                    age[i][j] <= (flush || alloc[i] || free[i] || free[j]) ? 1'b0 :
                                 alloc[j] ? 1'b1 : age[i][j];
        end
    end

    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int i = 0; i < RS_N; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_N; j++) blocked = blocked | (req[j] & age[j][i]);
            grant[i] = req[i] & ~blocked;
        end
    end
endmodule

// File: rtl/rs_alu_station.sv
// rs_alu_station: reservation station holding dispatched ALU ops until operands arrive, issuing oldest-ready
// Ports: clk, rst (async, active-high), flush (sync squash), snp_valid/snp_ready/snp_val
//        (ROB broadcast, entry k at snp_val[k*DATA_W +: DATA_W]), bus (slave side of
//        rs_alu_station_if: dispatch request + full, issue valid/ready + op/operands/tag).
module rs_alu_station
    import rs_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [ROB_N-1:0]        snp_valid,
    input  logic [ROB_N-1:0]        snp_ready,
    input  logic [ROB_N*DATA_W-1:0] snp_val,
    rs_alu_station_if.slave         bus
);
    rs_entry           ent [RS_N];
    rs_entry           new_ent;
    logic [DATA_W-1:0] snp_word [ROB_N];
    logic [RS_N-1:0]   valid, req, grant, alloc, free;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic              disp_fire, load;

    for (genvar k = 0; k < ROB_N; k++) begin : g_snp
        assign snp_word[k] = snp_val[k*DATA_W +: DATA_W];
    end

    // ROB entry t has its result available this cycle
    function automatic logic hit(input tag_t t);
        return tag_real(t) && snp_valid[tag_idx(t)] && snp_ready[tag_idx(t)];
    endfunction

    always_comb begin
        valid    = '0;
        req      = '0;
        free_idx = '0;
        for (int i = RS_N - 1; i >= 0; i--) begin
            valid[i] = ent[i].valid;
            req[i]   = ent[i].valid && ent[i].a_rdy && ent[i].b_rdy;
            if (!ent[i].valid) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_N; i++) if (grant[i]) sel_idx = IDX_W'(i);
    end

    // Full is taken before any same-edge departure, so a freed slot is reusable only next cycle.
    assign bus.full  = &valid;
    assign disp_fire = bus.disp_valid && !bus.full && !flush;
    assign alloc     = disp_fire ? {{(RS_N-1){1'b0}}, 1'b1} << free_idx : '0;
    assign load      = |grant && (!bus.iss_valid || bus.iss_ready);
    assign free      = load ? grant : '0;

    // Dispatch-time snoop also covers a result broadcast on the very same edge.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.op      = bus.disp_op;
        new_ent.dst_tag = bus.disp_tag;
        new_ent.a_tag   = bus.disp_a_tag;
        new_ent.b_tag   = bus.disp_b_tag;
        new_ent.a_rdy   = bus.disp_a_tag == TAG_INVALID || hit(bus.disp_a_tag);
        new_ent.b_rdy   = bus.disp_b_tag == TAG_INVALID || hit(bus.disp_b_tag);
        new_ent.a_val   = bus.disp_a_tag == TAG_INVALID ? bus.disp_a_val : snp_word[tag_idx(bus.disp_a_tag)];
        new_ent.b_val   = bus.disp_b_tag == TAG_INVALID ? bus.disp_b_val : snp_word[tag_idx(bus.disp_b_tag)];
    end

    rs_age_select u_age (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .alloc (alloc),
        .free  (free),
        .req   (req),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_N; i++) ent[i] <= '0;
        end else begin
            for (int i = 0; i < RS_N; i++) begin
                if (flush) begin
                    ent[i].valid <= 1'b0;
                end else if (alloc[i]) begin
                    ent[i] <= new_ent;
                end else begin
                    if (free[i]) ent[i].valid <= 1'b0;
                    if (ent[i].valid && !ent[i].a_rdy && hit(ent[i].a_tag)) begin
                        ent[i].a_rdy <= 1'b1;
                        ent[i].a_val <= snp_word[tag_idx(ent[i].a_tag)];
                    end
                    if (ent[i].valid && !ent[i].b_rdy && hit(ent[i].b_tag)) begin
                        ent[i].b_rdy <= 1'b1;
                        ent[i].b_val <= snp_word[tag_idx(ent[i].b_tag)];
                    end
                end
            end
        end
    end

    // Issue register: loads only when empty or being drained, otherwise holds stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.iss_valid <= 1'b0;
            bus.iss_op    <= '0;
            bus.iss_a     <= '0;
            bus.iss_b     <= '0;
            bus.iss_tag   <= TAG_INVALID;
        end else if (flush) begin
            bus.iss_valid <= 1'b0;
        end else if (load) begin
            bus.iss_valid <= 1'b1;
            bus.iss_op    <= ent[sel_idx].op;
            bus.iss_a     <= ent[sel_idx].a_val;
            bus.iss_b     <= ent[sel_idx].b_val;
            bus.iss_tag   <= ent[sel_idx].dst_tag;
        end else if (bus.iss_ready) begin
            bus.iss_valid <= 1'b0;
        end
    end

    a_legal_tags: assert property (@(posedge clk) disable iff (rst)
        bus.disp_valid |-> tag_real(bus.disp_tag)
                        && (tag_real(bus.disp_a_tag) || bus.disp_a_tag == TAG_INVALID)
                        && (tag_real(bus.disp_b_tag) || bus.disp_b_tag == TAG_INVALID));
endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: directed stimulus against a sequence-numbered behavioural model of the station
module tb_rs_alu_station;
    import rs_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic [ROB_N-1:0]        snp_valid = '0;
    logic [ROB_N-1:0]        snp_ready = '0;
    logic [ROB_N*DATA_W-1:0] snp_val = '0;
    int                      total = 0;
    int                      bad = 0;
    bit                      started = 0;

    rs_alu_station_if bus();

    rs_alu_station dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .snp_valid (snp_valid),
        .snp_ready (snp_ready),
        .snp_val   (snp_val),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Model: entries carry a dispatch sequence number; oldest ready = smallest number.
    typedef struct {
        bit                v;
        int                seq;
        logic [OP_W-1:0]   op;
        tag_t              dst;
        bit                ar, br;
        tag_t              at, bt;
        logic [DATA_W-1:0] av, bv;
    } m_ent_t;

    m_ent_t            m [RS_N];
    bit                m_iv = 0;
    logic [OP_W-1:0]   m_op = '0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0;
    tag_t              m_tag = TAG_INVALID;
    int                seq_cnt = 0;
    int                c, f;
    bit                fullm;

    function automatic bit rob_has(input tag_t t);
        return int'(t) < ROB_N && snp_valid[int'(t)] && snp_ready[int'(t)];
    endfunction

    function automatic logic [DATA_W-1:0] rob_val(input tag_t t);
        return int'(t) < ROB_N ? snp_val[int'(t)*DATA_W +: DATA_W] : '0;
    endfunction

    function automatic bit m_full();
        bit r = 1;
        foreach (m[i]) if (!m[i].v) r = 0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m[i]) m[i].v = 0;
            m_iv = 0; m_op = '0; m_a = '0; m_b = '0; m_tag = TAG_INVALID;
        end else begin
            fullm = 1; f = -1; c = -1;
            foreach (m[i]) if (!m[i].v) begin
                fullm = 0;
                if (f < 0) f = i;
            end
            foreach (m[i])
                if (m[i].v && m[i].ar && m[i].br && (c < 0 || m[i].seq < m[c].seq)) c = i;
            if (flush) begin
                foreach (m[i]) m[i].v = 0;
                m_iv = 0;
            end else begin
                if (c >= 0 && (!m_iv || bus.iss_ready)) begin
                    m_iv = 1; m_op = m[c].op; m_a = m[c].av; m_b = m[c].bv; m_tag = m[c].dst;
                    m[c].v = 0;
                end else if (bus.iss_ready) begin
                    m_iv = 0;
                end
                foreach (m[i]) if (m[i].v) begin
                    if (!m[i].ar && rob_has(m[i].at)) begin m[i].ar = 1; m[i].av = rob_val(m[i].at); end
                    if (!m[i].br && rob_has(m[i].bt)) begin m[i].br = 1; m[i].bv = rob_val(m[i].bt); end
                end
                if (bus.disp_valid && !fullm) begin
                    m[f].v   = 1;
                    m[f].seq = seq_cnt++;
                    m[f].op  = bus.disp_op;
                    m[f].dst = bus.disp_tag;
                    m[f].at  = bus.disp_a_tag;
                    m[f].bt  = bus.disp_b_tag;
                    m[f].ar  = bus.disp_a_tag == TAG_INVALID || rob_has(bus.disp_a_tag);
                    m[f].br  = bus.disp_b_tag == TAG_INVALID || rob_has(bus.disp_b_tag);
                    m[f].av  = bus.disp_a_tag == TAG_INVALID ? bus.disp_a_val : rob_val(bus.disp_a_tag);
                    m[f].bv  = bus.disp_b_tag == TAG_INVALID ? bus.disp_b_val : rob_val(bus.disp_b_tag);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("m_full", bus.full, m_full());
        chk("m_iss_valid", bus.iss_valid, m_iv);
        chk("m_iss_op", bus.iss_op, m_op);
        chk("m_iss_a", bus.iss_a, m_a);
        chk("m_iss_b", bus.iss_b, m_b);
        chk("m_iss_tag", bus.iss_tag, m_tag);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input tag_t dst, input tag_t at, input logic [31:0] av,
                        input tag_t bt, input logic [31:0] bv, input logic [5:0] op);
        bus.disp_valid = 1'b1; bus.disp_tag = dst; bus.disp_op = op;
        bus.disp_a_tag = at; bus.disp_a_val = av; bus.disp_b_tag = bt; bus.disp_b_val = bv;
        tick();
        bus.disp_valid = 1'b0; bus.disp_a_tag = TAG_INVALID; bus.disp_b_tag = TAG_INVALID;
    endtask

    task automatic rob_set(input int t, input logic [31:0] v);
        snp_valid[t] = 1'b1; snp_ready[t] = 1'b1; snp_val[t*DATA_W +: DATA_W] = v;
    endtask

    task automatic rob_clr(input int t);
        snp_valid[t] = 1'b0; snp_ready[t] = 1'b0;
    endtask

    initial begin
        bus.disp_valid = 0; bus.disp_op = '0; bus.disp_tag = '0;
        bus.disp_a_tag = TAG_INVALID; bus.disp_b_tag = TAG_INVALID;
        bus.disp_a_val = '0; bus.disp_b_val = '0; bus.iss_ready = 0;
        tick(); tick();
        rst = 0; started = 1;
        tick();
        chk("rst_full", bus.full, 0);
        chk("rst_valid", bus.iss_valid, 0);
        chk("rst_tag", bus.iss_tag, TAG_INVALID);
        chk("rst_a", bus.iss_a, 0);

        // both operands known at dispatch: issue two edges later
        bus.iss_ready = 1;
        disp(3, TAG_INVALID, 5, TAG_INVALID, 7, 1);
        chk("t1_early", bus.iss_valid, 0);
        tick();
        chk("t1_valid", bus.iss_valid, 1);
        chk("t1_a", bus.iss_a, 5);
        chk("t1_b", bus.iss_b, 7);
        chk("t1_tag", bus.iss_tag, 3);
        chk("t1_full", bus.full, 0);
        tick();

        // operand a waits on ROB tag 2
        disp(4, 2, 0, TAG_INVALID, 1, 2);
        repeat (3) tick();
        chk("t2_wait", bus.iss_valid, 0);
        rob_set(2, 32'h10);
        tick();
        chk("t2_wake_edge", bus.iss_valid, 0);
        tick();
        chk("t2_valid", bus.iss_valid, 1);
        chk("t2_a", bus.iss_a, 32'h10);
        chk("t2_tag", bus.iss_tag, 4);
        rob_clr(2);
        tick();

        // fill on tag 6, fifth dispatch rejected, drain in dispatch order
        for (int d = 0; d < 4; d++) disp(tag_t'(d), 6, 0, TAG_INVALID, 32'(d + 100), 3);
        chk("t3_full", bus.full, 1);
        disp(5, TAG_INVALID, 1, TAG_INVALID, 2, 4);
        chk("t3_full_hold", bus.full, 1);
        chk("t3_none", bus.iss_valid, 0);
        rob_set(6, 32'h66);
        tick();
        for (int d = 0; d < 4; d++) begin
            tick();
            chk("t3_order_valid", bus.iss_valid, 1);
            chk("t3_order_tag", bus.iss_tag, d);
            chk("t3_order_a", bus.iss_a, 32'h66);
            chk("t3_order_b", bus.iss_b, d + 100);
        end
        tick();
        chk("t3_drained", bus.iss_valid, 0);
        rob_clr(6);

        // back-pressure holds the issue slot
        bus.iss_ready = 0;
        disp(1, TAG_INVALID, 11, TAG_INVALID, 0, 5);
        disp(2, TAG_INVALID, 22, TAG_INVALID, 0, 5);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", bus.iss_valid, 1);
            chk("t4_hold_tag", bus.iss_tag, 1);
            chk("t4_hold_a", bus.iss_a, 11);
        end
        bus.iss_ready = 1;
        tick();
        chk("t4_next_tag", bus.iss_tag, 2);
        chk("t4_next_a", bus.iss_a, 22);
        tick();
        chk("t4_empty", bus.iss_valid, 0);

        // flush with a held issue and pending entries
        bus.iss_ready = 0;
        disp(0, TAG_INVALID, 1, TAG_INVALID, 2, 6);
        disp(1, 5, 0, TAG_INVALID, 0, 6);
        disp(2, 5, 0, TAG_INVALID, 0, 6);
        disp(3, 5, 0, TAG_INVALID, 0, 6);
        chk("t5_pre_valid", bus.iss_valid, 1);
        chk("t5_pre_full", bus.full, 0);
        flush = 1;
        tick();
        flush = 0;
        chk("t5_valid", bus.iss_valid, 0);
        chk("t5_full", bus.full, 0);
        bus.iss_ready = 1;
        disp(7, TAG_INVALID, 32'h77, TAG_INVALID, 32'h78, 7);
        tick();
        chk("t5_new_valid", bus.iss_valid, 1);
        chk("t5_new_tag", bus.iss_tag, 7);
        chk("t5_new_a", bus.iss_a, 32'h77);
        tick();

        // asynchronous reset mid-cycle
        bus.iss_ready = 0;
        disp(2, TAG_INVALID, 5, TAG_INVALID, 0, 8);
        disp(3, 4, 0, TAG_INVALID, 0, 8);
        tick();
        chk("t6_pre_valid", bus.iss_valid, 1);
        #2 rst = 1;
        #1;
        chk("t6_async_valid", bus.iss_valid, 0);
        chk("t6_async_tag", bus.iss_tag, TAG_INVALID);
        chk("t6_async_full", bus.full, 0);
        @(negedge clk);
        #1 rst = 0;
        bus.iss_ready = 1;
        rob_set(4, 32'h44);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_quiet", bus.iss_valid, 0);
        end
        rob_clr(4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
